// File: rtl/tdc_pkg.sv
// Shared sizing, types and helpers for the TDC thermometer decoder.
package tdc_pkg;

  localparam int NTDC  = 64;
  localparam int IDX_W = $clog2(NTDC);

  typedef logic [NTDC-1:0]  tdc_vec_t;
  typedef logic [IDX_W-1:0] tdc_idx_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tdc_edge_finder.sv
// Combinational priority encoder: lowest index k>=1 where vec steps from ~pol to pol.
module tdc_edge_finder
  import tdc_pkg::*;
(
  input  tdc_vec_t vec,
  input  logic     pol,
  output tdc_idx_t idx,
  output logic     found
);

  // Scan downwards so the lowest matching transition is the one that sticks.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NTDC - 1; k >= 1; k--) begin
      if ((vec[k-1] != pol) && (vec[k] == pol)) begin
        idx   = tdc_idx_t'(k);
        found = 1'b1;
      end else begin
        idx   = idx;
        found = found;
      end
    end
  end

endmodule

// File: rtl/tdc_decoder.sv
// TDC thermometer decoder: capture, bubble correction, edge location, then
// phase output, half-period IIR averager and saturating edge-miss counter.
module tdc_decoder
  import tdc_pkg::*;
#(
  parameter int AVG_SHIFT = 3
)
(
  input  logic       ref_clk,
  input  logic       rst_n,
  input  logic       tdc_en,
  input  logic       avg_clr,
  input  tdc_vec_t   sampled_tdc,
  output tdc_idx_t   phase_code,
  output logic       phase_valid,
  output logic [6:0] period_est,
  output logic       period_valid,
  output logic       no_edge,
  output logic [7:0] miss_cnt
);

  localparam int AVG_W = IDX_W + AVG_SHIFT;

  tdc_vec_t          s0_vec_r;
  logic              v0_r;
  tdc_vec_t          corr_s;
  tdc_vec_t          c1_r;
  logic              v1_r;
  tdc_idx_t          rise_s;
  tdc_idx_t          fall_s;
  logic              rise_found_s;
  logic              fall_found_s;
  tdc_idx_t          rise_r;
  tdc_idx_t          fall_r;
  logic              rise_found_r;
  logic              fall_found_r;
  logic              v2_r;

  tdc_idx_t          hp_s;
  logic [AVG_W-1:0]  avg_upd_s;
  logic [AVG_W-1:0]  avg_nxt_s;
  logic              seeded_nxt_s;
  logic [AVG_W-1:0]  avg_r;
  logic              seeded_r;
  tdc_idx_t          phase_code_r;
  logic              phase_valid_r;
  logic [6:0]        period_est_r;
  logic              no_edge_r;
  logic [7:0]        miss_cnt_r;

  // Majority-of-three across neighbours removes single-cell bubbles.
  always_comb begin
    corr_s = s0_vec_r;
    for (int n = 1; n <= NTDC - 2; n++) begin
      corr_s[n] = maj3(s0_vec_r[n-1], s0_vec_r[n], s0_vec_r[n+1]);
    end
  end

  tdc_edge_finder u_rise (
    .vec   (c1_r),
    .pol   (1'b1),
    .idx   (rise_s),
    .found (rise_found_s)
  );

  tdc_edge_finder u_fall (
    .vec   (c1_r),
    .pol   (1'b0),
    .idx   (fall_s),
    .found (fall_found_s)
  );

  // Pipeline stages S0 (capture), S1 (corrected vector) and S2 (edge indices).
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vec_r     <= '0;
      v0_r         <= 1'b0;
      c1_r         <= '0;
      v1_r         <= 1'b0;
      rise_r       <= '0;
      fall_r       <= '0;
      rise_found_r <= 1'b0;
      fall_found_r <= 1'b0;
      v2_r         <= 1'b0;
    end else begin
      v0_r <= tdc_en;
      if (tdc_en) begin
        s0_vec_r <= sampled_tdc;
      end else begin
        s0_vec_r <= s0_vec_r;
      end
      c1_r         <= corr_s;
      v1_r         <= v0_r;
      rise_r       <= rise_s;
      fall_r       <= fall_s;
      rise_found_r <= rise_found_s;
      fall_found_r <= fall_found_s;
      v2_r         <= v1_r;
    end
  end

  // Averager next state; the first valid half-period seeds avg at steady-state scale.
  always_comb begin
    if (rise_r > fall_r) begin
      hp_s = rise_r - fall_r;
    end else begin
      hp_s = fall_r - rise_r;
    end

    if (seeded_r) begin
      avg_upd_s = avg_r - (avg_r >> AVG_SHIFT) + AVG_W'(hp_s);
    end else begin
      avg_upd_s = AVG_W'(hp_s) << AVG_SHIFT;
    end

    if (avg_clr) begin
      avg_nxt_s    = '0;
      seeded_nxt_s = 1'b0;
    end else if (v2_r && rise_found_r && fall_found_r) begin
      avg_nxt_s    = avg_upd_s;
      seeded_nxt_s = 1'b1;
    end else begin
      avg_nxt_s    = avg_r;
      seeded_nxt_s = seeded_r;
    end
  end

  // S3 registered outputs, averager state and miss counter.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_r         <= '0;
      seeded_r      <= 1'b0;
      phase_code_r  <= '0;
      phase_valid_r <= 1'b0;
      period_est_r  <= 7'd0;
      no_edge_r     <= 1'b0;
      miss_cnt_r    <= 8'd0;
    end else begin
      avg_r         <= avg_nxt_s;
      seeded_r      <= seeded_nxt_s;
      period_est_r  <= 7'(avg_nxt_s >> (AVG_SHIFT - 1));
      phase_valid_r <= v2_r & rise_found_r;
      no_edge_r     <= v2_r & ~rise_found_r;
      if (v2_r && rise_found_r) begin
        phase_code_r <= rise_r;
      end else begin
        phase_code_r <= phase_code_r;
      end
      if (v2_r && !rise_found_r && (miss_cnt_r != 8'd255)) begin
        miss_cnt_r <= miss_cnt_r + 8'd1;
      end else begin
        miss_cnt_r <= miss_cnt_r;
      end
    end
  end

  assign phase_code   = phase_code_r;
  assign phase_valid  = phase_valid_r;
  assign period_est   = period_est_r;
  assign period_valid = seeded_r;
  assign no_edge      = no_edge_r;
  assign miss_cnt     = miss_cnt_r;

endmodule

// File: tb/tb_tdc_decoder.sv
// Self-checking bench for tdc_decoder: directed scenarios plus random stimulus
// against a queue-based behavioural model.
module tb_tdc_decoder;

  localparam int S = 3;

  logic        ref_clk;
  logic        rst_n;
  logic        tdc_en;
  logic        avg_clr;
  logic [63:0] sampled_tdc;
  logic [5:0]  phase_code;
  logic        phase_valid;
  logic [6:0]  period_est;
  logic        period_valid;
  logic        no_edge;
  logic [7:0]  miss_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] q_vec[$];
  bit          q_en[$];
  int m_avg, m_seeded, m_miss, m_pc, m_pe;
  bit m_pv, m_ne;

  tdc_decoder #(.AVG_SHIFT(S)) dut (
    .ref_clk      (ref_clk),
    .rst_n        (rst_n),
    .tdc_en       (tdc_en),
    .avg_clr      (avg_clr),
    .sampled_tdc  (sampled_tdc),
    .phase_code   (phase_code),
    .phase_valid  (phase_valid),
    .period_est   (period_est),
    .period_valid (period_valid),
    .no_edge      (no_edge),
    .miss_cnt     (miss_cnt)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] therm(input int lo_end, input int hi_start);
    logic [63:0] v;
    for (int n = 0; n < 64; n++) v[n] = (n < lo_end || n >= hi_start) ? 1'b1 : 1'b0;
    return v;
  endfunction

  // Smooth by neighbour majority, then locate the first 0->1 and 1->0 steps.
  task automatic model_find(input logic [63:0] v, output int rise, output int fall);
    int c[64];
    c[0]  = int'(v[0]);
    c[63] = int'(v[63]);
    for (int n = 1; n < 63; n++)
      c[n] = ((int'(v[n-1]) + int'(v[n]) + int'(v[n+1])) >= 2) ? 1 : 0;
    rise = -1;
    fall = -1;
    for (int k = 1; k < 64; k++) begin
      if (rise < 0 && c[k-1] == 0 && c[k] == 1) rise = k;
      if (fall < 0 && c[k-1] == 1 && c[k] == 0) fall = k;
    end
  endtask

  task automatic model_step();
    bit en;
    logic [63:0] v;
    int rise, fall, hp;
    m_pv = 1'b0;
    m_ne = 1'b0;
    if (!rst_n) begin
      q_vec.delete();
      q_en.delete();
      m_avg = 0; m_seeded = 0; m_miss = 0; m_pc = 0; m_pe = 0;
      return;
    end
    q_en.push_back(tdc_en);
    q_vec.push_back(sampled_tdc);
    if (q_en.size() > 3) begin
      en = q_en.pop_front();
      v  = q_vec.pop_front();
      if (en) begin
        model_find(v, rise, fall);
        if (rise >= 0) begin
          m_pv = 1'b1;
          m_pc = rise;
        end else begin
          m_ne = 1'b1;
          m_miss = (m_miss < 255) ? m_miss + 1 : 255;
        end
        if (rise >= 0 && fall >= 0) begin
          hp = (rise > fall) ? rise - fall : fall - rise;
          if (m_seeded != 0) m_avg = m_avg - m_avg / (1 << S) + hp;
          else m_avg = hp * (1 << S);
          m_seeded = 1;
        end
      end
    end
    if (avg_clr) begin
      m_avg = 0;
      m_seeded = 0;
    end
    m_pe = m_avg / (1 << (S - 1));
  endtask

  task automatic compare_all();
    chk("phase_code",   int'(phase_code),   m_pc);
    chk("phase_valid",  int'(phase_valid),  int'(m_pv));
    chk("no_edge",      int'(no_edge),      int'(m_ne));
    chk("miss_cnt",     int'(miss_cnt),     m_miss);
    chk("period_est",   int'(period_est),   m_pe);
    chk("period_valid", int'(period_valid), m_seeded);
  endtask

  task automatic cycle(input bit en, input logic [63:0] v, input bit clr);
    tdc_en = en;
    sampled_tdc = v;
    avg_clr = clr;
    @(posedge ref_clk);
    model_step();
    @(negedge ref_clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] clean, bub, v;
    int per, off;
    rst_n = 1'b0;
    tdc_en = 1'b0;
    avg_clr = 1'b0;
    sampled_tdc = 64'd0;
    clean = therm(10, 30);
    bub = clean;
    bub[35] = 1'b0;
    @(negedge ref_clk);

    idle(5);
    chk("rst_phase_code", int'(phase_code), 0);
    chk("rst_period_valid", int'(period_valid), 0);
    chk("rst_miss_cnt", int'(miss_cnt), 0);
    chk("rst_period_est", int'(period_est), 0);
    rst_n = 1'b1;

    cycle(1'b1, clean, 1'b0);
    idle(2);
    chk("clean_pre_pulse", int'(phase_valid), 0);
    idle(1);
    chk("clean_phase_valid", int'(phase_valid), 1);
    chk("clean_phase_code", int'(phase_code), 30);
    chk("clean_period_est", int'(period_est), 40);
    chk("clean_period_valid", int'(period_valid), 1);

    cycle(1'b1, bub, 1'b0);
    idle(3);
    chk("bubble_phase_code", int'(phase_code), 30);
    chk("bubble_period_est", int'(period_est), 40);

    for (int i = 0; i < 300; i++) cycle(1'b1, {64{1'b1}}, 1'b0);
    idle(3);
    chk("miss_saturated", int'(miss_cnt), 255);
    chk("miss_period_hold", int'(period_est), 40);
    chk("miss_phase_hold", int'(phase_code), 30);

    cycle(1'b1, therm(10, 38), 1'b0);
    idle(3);
    chk("iir_step", int'(period_est), 42);
    for (int i = 0; i < 80; i++) cycle(1'b1, therm(10, 38), 1'b0);
    idle(3);
    chk("iir_converged", int'(period_est), 56);

    cycle(1'b0, 64'd0, 1'b1);
    chk("clr_period_valid", int'(period_valid), 0);
    cycle(1'b1, therm(10, 22), 1'b0);
    idle(3);
    chk("reseed_period_est", int'(period_est), 24);
    chk("reseed_period_valid", int'(period_valid), 1);

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        rst_n = 1'b0;
        idle(3);
        chk("midrst_miss_cnt", int'(miss_cnt), 0);
        chk("midrst_period_valid", int'(period_valid), 0);
        rst_n = 1'b1;
      end
      case ($urandom_range(0, 3))
        0: v = {$urandom, $urandom};
        1: v = ($urandom_range(0, 1) == 0) ? 64'd0 : {64{1'b1}};
        default: begin
          per = $urandom_range(2, 40);
          off = $urandom_range(0, 79);
          for (int n = 0; n < 64; n++) v[n] = (((n + off) / per) % 2) != 0;
          if ($urandom_range(0, 2) == 0) v[$urandom_range(0, 63)] ^= 1'b1;
        end
      endcase
      cycle(($urandom_range(0, 3) != 0), v, ($urandom_range(0, 49) == 0));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_decoder.md
# tdc_decoder

Converts the raw 64-bit thermometer sample vector from the TDC into a DCO phase code and a running estimate of the DCO period, in delay-cell units, for the DPLL loop filter. It sits directly downstream of the TDC and upstream of the phase-error / loop-filter logic, and it runs on the reference clock. It is a 3-stage pipeline with bubble correction, edge location, a half-period IIR averager and a saturating edge-miss counter.

## Interface
- NTDC, 64: TDC chain length; the sample vector width.
- AVG_SHIFT, 3: IIR averaging weight, 2^-AVG_SHIFT; legal range 1..6.
- ref_clk  input  1: reference clock; the TDC sample clock.
- rst_n  input  1: asynchronous active-low reset.
- tdc_en  input  1: when low, the input vector is not captured and no valid result is produced.
- avg_clr  input  1: synchronous; clears the averager and its seeded flag.
- sampled_tdc  input  NTDC: TDC sample vector; bit n is the DCO level at ref edge + n·dt.
- phase_code  output  6: index of the first DCO rising edge in the vector.
- phase_valid  output  1: one-cycle pulse; phase_code is valid.
- period_est  output  7: averaged DCO period estimate (2·half-period), integer cells.
- period_valid  output  1: level; high once the averager is seeded.
- no_edge  output  1: one-cycle pulse; the captured vector had no rising edge.
- miss_cnt  output  8: saturating count of no_edge events.

## Operation
- S0, capture: sampled_tdc is registered on posedge ref_clk when tdc_en=1, along with a stage valid bit v0 = tdc_en.
  - The chain settles within NTDC·dt (256 ps), well inside one ref period, so the captured vector belongs to the previous ref edge.
- S1, bubble correction:
  - c[n] = majority(s[n-1], s[n], s[n+1]) for n = 1..NTDC-2.
  - c[0] = s[0] and c[NTDC-1] = s[NTDC-1].
- S2, edge find:
  - rise = lowest k in 1..NTDC-1 with c[k-1]=0 and c[k]=1.
  - fall = lowest k with c[k-1]=1 and c[k]=0.
  - Each edge has a found flag.
- S3, output and averager:
  - Rise found: phase_code = rise and phase_valid pulses.
  - No rise: no_edge pulses and miss_cnt increments, saturating at 255. phase_code holds its last value.
  - Both edges found: hp = |rise - fall|, 6-bit, 1..63.
    - Averager unseeded: avg = hp << AVG_SHIFT and the averager becomes seeded.
    - Averager seeded: avg = avg - (avg >> AVG_SHIFT) + hp.
  - avg is 6+AVG_SHIFT bits, unsigned, and never overflows.
  - period_est = avg >> (AVG_SHIFT-1), i.e. 2·hp at steady state.
- When an edge is missing, avg and period_est are unchanged.
- avg_clr applied in the same cycle as an S3 update: the clear wins, and the seeded flag is cleared.
- Reset: every pipeline register, valid bit, avg, the seeded flag, miss_cnt and every output go to 0.

## Timing
- Latency: a vector captured at edge N produces outputs registered at edge N+3.
- Throughput: one vector per ref cycle.
- tdc_en low: the bubble travels down the pipe, so there is no pulse 3 cycles later. Stages already in flight complete.
- Outputs update only on a ref_clk edge. phase_valid and no_edge never assert together.
- Reset asserted mid-stream: in-flight results are discarded. The first result after deassertion comes 3 cycles after the first capture.

## Structure
- Package tdc_pkg holds:
  - NTDC and IDX_W = $clog2(NTDC);
  - typedef tdc_vec_t (logic [NTDC-1:0]);
  - typedef tdc_idx_t (logic [IDX_W-1:0]).
- Sub-module tdc_edge_finder: combinational priority encoder taking a vector and a polarity, returning the index and a found flag. It is instantiated twice in S2.

## Test plan
- Reset: hold rst_n=0 for 5 cycles -> all outputs 0, period_valid=0, miss_cnt=0.
- Clean vector, bits 0–9=1, 10–29=0, 30–63=1 -> 3 cycles later phase_code=30, phase_valid pulses, period_est=40, period_valid=1.
- Bubble: the previous vector with bit 35 forced to 0 -> output identical to the clean case.
- All-ones vector -> no_edge pulses, phase_valid=0, miss_cnt+1, period_est unchanged. Run 300 such cycles -> miss_cnt saturates at 255.
- IIR, AVG_SHIFT=3: seed with hp=20 (avg=160), then apply hp=28 -> avg=168, period_est=42. With continued hp=28, period_est converges to 56.
- avg_clr pulse, then a clean hp=12 vector -> period_valid drops, then reseeds with period_est=24. Reset during streaming -> identical to the reset scenario.
